spi_transmitter: RTL and testbench



---
 rtl/spi_transmitter.sv | 149 ++++++++++++++
 tb/tb_spi_transmitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transmitter.sv
// Audio SPI link serializer: one DATA_WIDTH sample per FRAME_BITS-bit frame,
// MSB first, zero padded, with a free-running serial clock and CS gap control.
module spi_transmitter #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FRAME_BITS   = 32,
    parameter int unsigned HALF_DIV     = 2,
    parameter int unsigned CS_IDLE_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  serial_clk,
    output logic                  chip_select,
    output logic                  mosi,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned GAP_W = $clog2(CS_IDLE_BITS + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  div_tc;
    logic                  fall_evt;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [BIT_W-1:0]      bit_idx;
    logic [BIT_W-1:0]      bit_idx_nxt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_nxt;
    logic                  cs_nxt;
    logic                  mosi_nxt;
    logic                  done_nxt;
    logic                  start_c;

    assign div_tc   = (div_cnt == DIV_W'(HALF_DIV - 1));
    assign fall_evt = div_tc && serial_clk;
    assign s_ready  = !hold_full;

    // Free-running serial clock divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            serial_clk <= 1'b0;
        end else if (div_tc) begin
            div_cnt    <= '0;
            serial_clk <= !serial_clk;
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
        end
    end

    // Holding register; load needs it empty and frame start needs it full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (start_c) begin
            hold_full <= 1'b0;
        end else if (s_valid && s_ready) begin
            hold_data <= s_data;
            hold_full <= 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            gap_cnt     <= GAP_W'(CS_IDLE_BITS);
            shift_reg   <= '0;
            chip_select <= 1'b1;
            mosi        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_idx     <= bit_idx_nxt;
            gap_cnt     <= gap_nxt;
            shift_reg   <= shift_nxt;
            chip_select <= cs_nxt;
            mosi        <= mosi_nxt;
            busy        <= (state_nxt == SHIFT);
            frame_done  <= done_nxt;
        end
    end

    // Next state; every line change lands on a serial_clk falling edge
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        gap_nxt     = gap_cnt;
        shift_nxt   = shift_reg;
        cs_nxt      = chip_select;
        mosi_nxt    = mosi;
        done_nxt    = 1'b0;
        start_c     = 1'b0;
        if (fall_evt) begin
            case (state)
                IDLE: begin
                    cs_nxt   = 1'b1;
                    mosi_nxt = 1'b0;
                    if (gap_cnt < GAP_W'(CS_IDLE_BITS)) begin
                        gap_nxt = gap_cnt + GAP_W'(1);
                    end
                    if (hold_full && ((32'(gap_cnt) + 32'd1) >= CS_IDLE_BITS)) begin
                        start_c     = 1'b1;
                        cs_nxt      = 1'b0;
                        mosi_nxt    = hold_data[DATA_WIDTH-1];
                        shift_nxt   = hold_data;
                        bit_idx_nxt = '0;
                        state_nxt   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_idx == BIT_W'(FRAME_BITS - 1)) begin
                        cs_nxt    = 1'b1;
                        mosi_nxt  = 1'b0;
                        gap_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        // Zero fill makes the padding bits fall out naturally
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                        shift_nxt   = shift_reg << 1;
                        mosi_nxt    = shift_nxt[DATA_WIDTH-1];
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transmitter.sv
// Scoreboarded bench for spi_transmitter: a receiver model reassembles frames
// and compares them against samples queued as they are accepted.
module tb_spi_transmitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        serial_clk;
    logic        chip_select;
    logic        mosi;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [31:0] frame_bits = '0;
    logic [15:0] rx_word = '0;
    logic [15:0] exp_word;
    int          bit_cnt = 0;
    int          gap_rises = 0;
    int          last_gap = -1;
    int          fd_cnt = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_mosi = 1'b0;

    spi_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .serial_clk  (serial_clk),
        .chip_select (chip_select),
        .mosi        (mosi),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream receiver model, sampled on the falling clk edge
    always @(negedge clk) begin
        if (reset) begin
            bit_cnt   = 0;
            gap_rises = 0;
        end else begin
            if (mosi !== prev_mosi) check("mosi_at_fall", 32'({prev_sclk, serial_clk}), 32'd2);
            if (chip_select !== prev_cs) check("cs_at_fall", 32'({prev_sclk, serial_clk}), 32'd2);
            if (frame_done) fd_cnt++;
            if (serial_clk && !prev_sclk) begin
                if (!chip_select) begin
                    if (bit_cnt == 0) last_gap = gap_rises;
                    frame_bits = {frame_bits[30:0], mosi};
                    bit_cnt++;
                    if (bit_cnt == 16) rx_word = frame_bits[15:0];
                end else begin
                    gap_rises++;
                end
            end
            if (chip_select && !prev_cs) begin
                check("frame_len", 32'(bit_cnt), 32'd32);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", frame_bits, 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("frame", frame_bits, {exp_word, 16'h0000});
                    check("rx_word", 32'(rx_word), 32'(exp_word));
                end
                bit_cnt   = 0;
                gap_rises = 0;
            end
        end
        prev_sclk = serial_clk;
        prev_cs   = chip_select;
        prev_mosi = mosi;
    end

    // Offer a sample from the current negedge until accepted
    task automatic send(input logic [15:0] d);
        int n;
        n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 1000), 32'd1);
        if (n < 1000) exp_q.push_back(d);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && chip_select && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int k;
        int fd0;
        int cs_bad;
        int mosi_bad;
        int per_bad;
        int rises;
        int last_rise;
        logic ps;

        // Reset values
        @(negedge clk);
        check("rst_sclk", 32'(serial_clk), 32'd0);
        check("rst_cs", 32'(chip_select), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("sclk_toggle", 32'(serial_clk), 32'((i / 2) % 2));
            check("idle_cs", 32'(chip_select), 32'd1);
        end

        // Single sample with start latency
        fd0 = fd_cnt;
        send(16'hA5C3);
        k = 0;
        while (chip_select && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("start_latency", 32'(k >= 1 && k <= 4), 32'd1);
        wait_idle();
        check("single_done", 32'(fd_cnt - fd0), 32'd1);

        // Back-to-back with s_valid held
        fd0 = fd_cnt;
        s_data  = 16'h8001;
        s_valid = 1'b1;
        k = 0;
        while (!s_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        exp_q.push_back(16'h8001);
        @(negedge clk);
        s_data = 16'h7FFE;
        check("b2b_held", 32'(s_ready), 32'd0);
        k = 0;
        while (chip_select && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("b2b_start", 32'(chip_select), 32'd0);
        check("b2b_ready_at_start", 32'(s_ready), 32'd1);
        exp_q.push_back(16'h7FFE);
        @(negedge clk);
        s_valid = 1'b0;
        check("b2b_accepted", 32'(s_ready), 32'd0);
        wait_idle();
        check("b2b_gap", 32'(last_gap), 32'd2);
        check("b2b_done", 32'(fd_cnt - fd0), 32'd2);

        // Backpressure: hold full while a frame is in flight
        send(16'h1111);
        send(16'h2222);
        s_data  = 16'h1234;
        s_valid = 1'b1;
        check("bp_ready", 32'(s_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check("bp_ready_late", 32'(s_ready), 32'd0);
        send(16'h1234);
        wait_idle();

        // Reset mid-frame with a sample pending
        send(16'hC3C3);
        send(16'h0F0F);
        k = 0;
        while (bit_cnt != 7 && k < 500) begin
            @(negedge clk);
            k++;
        end
        while (serial_clk && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("mid_reach", 32'(k < 500), 32'd1);
        check("mid_mosi_before", 32'(mosi), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_cs", 32'(chip_select), 32'd1);
        check("mid_mosi", 32'(mosi), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(16'hFFFF);
        wait_idle();

        // Underrun
        fd0 = fd_cnt;
        cs_bad = 0;
        mosi_bad = 0;
        per_bad = 0;
        rises = 0;
        last_rise = -1;
        ps = serial_clk;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (chip_select !== 1'b1) cs_bad++;
            if (mosi !== 1'b0) mosi_bad++;
            if (serial_clk && !ps) begin
                if (last_rise >= 0 && (c - last_rise) != 4) per_bad++;
                last_rise = c;
                rises++;
            end
            ps = serial_clk;
        end
        check("ur_cs", 32'(cs_bad), 32'd0);
        check("ur_mosi", 32'(mosi_bad), 32'd0);
        check("ur_done", 32'(fd_cnt - fd0), 32'd0);
        check("ur_period", 32'(per_bad), 32'd0);
        check("ur_rises", 32'(rises), 32'd50);
        check("ur_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
